// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with WB bypass at capture, MEM/WB operand forwarding
// for the EX slot, and load-use hazard detection.
module idex_operand_stage #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic            i_id_valid,
   input  logic            i_id_rd_wren,
   input  logic            i_id_is_load,
   input  logic            i_id_use_rs1,
   input  logic            i_id_use_rs2,
   input  logic [4:0]      i_id_rs1_addr,
   input  logic [4:0]      i_id_rs2_addr,
   input  logic [4:0]      i_id_rd_addr,
   input  logic [XLEN-1:0] i_id_pc,
   input  logic [XLEN-1:0] i_id_imm,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic            i_wb_wren,
   input  logic [4:0]      i_wb_rd_addr,
   input  logic [XLEN-1:0] i_wb_rd_data,
   input  logic            i_mem_wren,
   input  logic [4:0]      i_mem_rd_addr,
   input  logic [XLEN-1:0] i_mem_alu_data,
   output logic            o_ex_valid,
   output logic            o_ex_rd_wren,
   output logic            o_ex_is_load,
   output logic [4:0]      o_ex_rs1_addr,
   output logic [4:0]      o_ex_rs2_addr,
   output logic [4:0]      o_ex_rd_addr,
   output logic [XLEN-1:0] o_ex_pc,
   output logic [XLEN-1:0] o_ex_imm,
   output logic [XLEN-1:0] o_ex_op_a,
   output logic [XLEN-1:0] o_ex_op_b,
   output logic [1:0]      o_fwd_sel_a,
   output logic [1:0]      o_fwd_sel_b,
   output logic            o_load_use
);

   logic            valid_q, valid_d;
   logic            rd_wren_q, rd_wren_d;
   logic            is_load_q, is_load_d;
   logic [4:0]      rs1_addr_q, rs1_addr_d;
   logic [4:0]      rs2_addr_q, rs2_addr_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] rs1_cap, rs2_cap;
   logic            load_use;

   always_comb begin
      load_use = i_id_valid & valid_q & is_load_q & (rd_addr_q != 5'd0) &
                 ((i_id_use_rs1 & (i_id_rs1_addr == rd_addr_q)) |
                  (i_id_use_rs2 & (i_id_rs2_addr == rd_addr_q)));

      // The register file is written on the same edge we capture, so bypass WB here.
      rs1_cap = (i_wb_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == i_id_rs1_addr))
                ? i_wb_rd_data : i_rs1_data;
      rs2_cap = (i_wb_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == i_id_rs2_addr))
                ? i_wb_rd_data : i_rs2_data;

      valid_d    = valid_q;
      rd_wren_d  = rd_wren_q;
      is_load_d  = is_load_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_addr_d  = rd_addr_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;

      if (i_flush) begin
         valid_d   = 1'b0;
         rd_wren_d = 1'b0;
         is_load_d = 1'b0;
      end else if (!i_stall) begin
         if (load_use) begin
            valid_d   = 1'b0;
            rd_wren_d = 1'b0;
            is_load_d = 1'b0;
         end else begin
            valid_d    = i_id_valid;
            rd_wren_d  = i_id_valid & i_id_rd_wren;
            is_load_d  = i_id_valid & i_id_is_load;
            rs1_addr_d = i_id_rs1_addr;
            rs2_addr_d = i_id_rs2_addr;
            rd_addr_d  = i_id_rd_addr;
            pc_d       = i_id_pc;
            imm_d      = i_id_imm;
            rs1_data_d = rs1_cap;
            rs2_data_d = rs2_cap;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q    <= 1'b0;
         rd_wren_q  <= 1'b0;
         is_load_q  <= 1'b0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         pc_q       <= '0;
         imm_q      <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
      end else begin
         valid_q    <= valid_d;
         rd_wren_q  <= rd_wren_d;
         is_load_q  <= is_load_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
      end
   end

   // An empty slot reports no forwarding and passes its captured operands through.
   always_comb begin
      o_fwd_sel_a = 2'b00;
      o_ex_op_a   = rs1_data_q;
      if (valid_q) begin
         if (i_mem_wren && (i_mem_rd_addr != 5'd0) && (i_mem_rd_addr == rs1_addr_q)) begin
            o_fwd_sel_a = 2'b01;
            o_ex_op_a   = i_mem_alu_data;
         end else if (i_wb_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == rs1_addr_q)) begin
            o_fwd_sel_a = 2'b10;
            o_ex_op_a   = i_wb_rd_data;
         end
      end

      o_fwd_sel_b = 2'b00;
      o_ex_op_b   = rs2_data_q;
      if (valid_q) begin
         if (i_mem_wren && (i_mem_rd_addr != 5'd0) && (i_mem_rd_addr == rs2_addr_q)) begin
            o_fwd_sel_b = 2'b01;
            o_ex_op_b   = i_mem_alu_data;
         end else if (i_wb_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == rs2_addr_q)) begin
            o_fwd_sel_b = 2'b10;
            o_ex_op_b   = i_wb_rd_data;
         end
      end
   end

   assign o_ex_valid    = valid_q;
   assign o_ex_rd_wren  = rd_wren_q;
   assign o_ex_is_load  = is_load_q;
   assign o_ex_rs1_addr = rs1_addr_q;
   assign o_ex_rs2_addr = rs2_addr_q;
   assign o_ex_rd_addr  = rd_addr_q;
   assign o_ex_pc       = pc_q;
   assign o_ex_imm      = imm_q;
   assign o_load_use    = load_use;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Scoreboarded random + directed bench for idex_operand_stage against a
// slot-level reference model of the ID/EX register and its forwarding rules.
module tb_idex_operand_stage;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            stall = 1'b0, flush = 1'b0;
   logic            id_valid = 1'b0, id_rd_wren = 1'b0, id_is_load = 1'b0;
   logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic [XLEN-1:0] id_pc = '0, id_imm = '0, rs1_data = '0, rs2_data = '0;
   logic            wb_wren = 1'b0;
   logic [4:0]      wb_rd = '0;
   logic [XLEN-1:0] wb_data = '0;
   logic            mem_wren = 1'b0;
   logic [4:0]      mem_rd = '0;
   logic [XLEN-1:0] mem_data = '0;

   logic            ex_valid, ex_rd_wren, ex_is_load, load_use;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic [XLEN-1:0] ex_pc, ex_imm, op_a, op_b;
   logic [1:0]      sel_a, sel_b;

   idex_operand_stage #(.XLEN(XLEN)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
      .i_id_valid(id_valid), .i_id_rd_wren(id_rd_wren), .i_id_is_load(id_is_load),
      .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
      .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2), .i_id_rd_addr(id_rd),
      .i_id_pc(id_pc), .i_id_imm(id_imm), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
      .i_wb_wren(wb_wren), .i_wb_rd_addr(wb_rd), .i_wb_rd_data(wb_data),
      .i_mem_wren(mem_wren), .i_mem_rd_addr(mem_rd), .i_mem_alu_data(mem_data),
      .o_ex_valid(ex_valid), .o_ex_rd_wren(ex_rd_wren), .o_ex_is_load(ex_is_load),
      .o_ex_rs1_addr(ex_rs1), .o_ex_rs2_addr(ex_rs2), .o_ex_rd_addr(ex_rd),
      .o_ex_pc(ex_pc), .o_ex_imm(ex_imm), .o_ex_op_a(op_a), .o_ex_op_b(op_b),
      .o_fwd_sel_a(sel_a), .o_fwd_sel_b(sel_b), .o_load_use(load_use)
   );

   always #5 clk = ~clk;

   // The instruction sitting in EX, as the model sees it.
   typedef struct packed {
      bit        valid, rd_wren, is_load;
      bit [4:0]  rs1, rs2, rd;
      bit [31:0] pc, imm, v1, v2;
   } slot_t;

   typedef struct packed {
      bit        valid, rd_wren, is_load, load_use;
      bit [4:0]  rs1, rs2, rd;
      bit [31:0] pc, imm, op_a, op_b;
      bit [1:0]  sel_a, sel_b;
   } exp_t;

   slot_t    slot = '0;
   exp_t     sb_q[$];
   event     mon_ev;
   int       tests = 0;
   int       fails = 0;
   int       txn = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Where a register index is being produced this cycle: 1 = MEM, 2 = WB, 0 = nowhere.
   function automatic bit [1:0] producer(input bit [4:0] r);
      if (r == 0) return 2'd0;
      if (mem_wren && mem_rd == r) return 2'd1;
      if (wb_wren && wb_rd == r) return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit [31:0] operand(input bit [1:0] src, input bit [31:0] held);
      case (src)
         2'd1:    return mem_data;
         2'd2:    return wb_data;
         default: return held;
      endcase
   endfunction

   function automatic bit hazard(input slot_t s);
      if (!(id_valid && s.valid && s.is_load && s.rd != 0)) return 1'b0;
      return (id_use_rs1 && id_rs1 == s.rd) || (id_use_rs2 && id_rs2 == s.rd);
   endfunction

   function automatic exp_t predict(input slot_t s);
      exp_t e;
      e.valid    = s.valid;
      e.rd_wren  = s.rd_wren;
      e.is_load  = s.is_load;
      e.load_use = hazard(s);
      e.rs1 = s.rs1; e.rs2 = s.rs2; e.rd = s.rd;
      e.pc  = s.pc;  e.imm = s.imm;
      e.sel_a = s.valid ? producer(s.rs1) : 2'd0;
      e.sel_b = s.valid ? producer(s.rs2) : 2'd0;
      e.op_a  = operand(e.sel_a, s.v1);
      e.op_b  = operand(e.sel_b, s.v2);
      return e;
   endfunction

   // Register-file read as seen at the writing edge: the WB value wins.
   function automatic bit [31:0] rf_read(input bit [4:0] r, input bit [31:0] raw);
      return (wb_wren && wb_rd != 0 && wb_rd == r) ? wb_data : raw;
   endfunction

   function automatic slot_t advance(input slot_t s);
      slot_t n = s;
      if (!rst_n) return '0;
      if (flush || (!stall && hazard(s))) begin
         n.valid = 0; n.rd_wren = 0; n.is_load = 0;
      end else if (!stall) begin
         n.valid   = id_valid;
         n.rd_wren = id_valid && id_rd_wren;
         n.is_load = id_valid && id_is_load;
         n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
         n.pc  = id_pc;  n.imm = id_imm;
         n.v1  = rf_read(id_rs1, rs1_data);
         n.v2  = rf_read(id_rs2, rs2_data);
      end
      return n;
   endfunction

   task automatic sample();
      sb_q.push_back(predict(slot));
      #1;
      ->mon_ev;
      #1;
   endtask

   // Inputs are set by the caller before this; they stay put across the edge.
   task automatic step();
      slot_t nxt = advance(slot);
      @(posedge clk);
      #1;
      slot = nxt;
      sample();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(mon_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            txn++;
            $display("[TB] txn %0d valid=%0b lu=%0b op_a=%h sel_a=%0d op_b=%h sel_b=%0d",
                     txn, ex_valid, load_use, op_a, sel_a, op_b, sel_b);
            chk("valid", 32'(ex_valid), 32'(e.valid));
            chk("rd_wren", 32'(ex_rd_wren), 32'(e.rd_wren));
            chk("is_load", 32'(ex_is_load), 32'(e.is_load));
            chk("load_use", 32'(load_use), 32'(e.load_use));
            chk("sel_a", 32'(sel_a), 32'(e.sel_a));
            chk("sel_b", 32'(sel_b), 32'(e.sel_b));
            if (e.valid) begin
               chk("rs1_addr", 32'(ex_rs1), 32'(e.rs1));
               chk("rs2_addr", 32'(ex_rs2), 32'(e.rs2));
               chk("rd_addr", 32'(ex_rd), 32'(e.rd));
               chk("pc", ex_pc, e.pc);
               chk("imm", ex_imm, e.imm);
               chk("op_a", op_a, e.op_a);
               chk("op_b", op_b, e.op_b);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic idle_fwd();
      wb_wren = 0; wb_rd = 0; wb_data = '0;
      mem_wren = 0; mem_rd = 0; mem_data = '0;
   endtask

   task automatic id_instr(input bit v, input bit wr, input bit ld, input bit [4:0] r1,
                           input bit [4:0] r2, input bit [4:0] rd, input bit [31:0] pc);
      id_valid = v; id_rd_wren = wr; id_is_load = ld;
      id_use_rs1 = 1; id_use_rs2 = 1;
      id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_pc = pc; id_imm = pc ^ 32'h0000_0F0F;
      rs1_data = (r1 == 0) ? 32'h0 : 32'h1000 + 32'(r1);
      rs2_data = (r2 == 0) ? 32'h0 : 32'h2000 + 32'(r2);
   endtask

   initial begin : stimulus
      // Reset state, held across an edge
      #2;
      sample();
      chk("rst_valid", 32'(ex_valid), 32'h0);
      chk("rst_pc", ex_pc, 32'h0);
      chk("rst_op_a", op_a, 32'h0);
      chk("rst_load_use", 32'(load_use), 32'h0);
      step();
      @(negedge clk);
      rst_n = 1;

      // WB bypass at capture
      id_instr(1, 1, 0, 5, 6, 9, 32'h100);
      rs1_data = 32'h11;
      wb_wren = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
      step();
      idle_fwd(); id_valid = 0; stall = 1;
      sample();
      chk("wb_bypass_op_a", op_a, 32'hDEADBEEF);
      chk("wb_bypass_sel_a", 32'(sel_a), 32'h0);
      step();
      stall = 0;

      // MEM over WB, then WB alone
      id_instr(1, 1, 0, 3, 4, 10, 32'h104);
      step();
      stall = 1; id_valid = 0;
      mem_wren = 1; mem_rd = 3; mem_data = 32'hA;
      wb_wren = 1; wb_rd = 3; wb_data = 32'hB;
      sample();
      chk("dbl_mem_op_a", op_a, 32'hA);
      chk("dbl_mem_sel_a", 32'(sel_a), 32'h1);
      mem_wren = 0;
      sample();
      chk("dbl_wb_op_a", op_a, 32'hB);
      chk("dbl_wb_sel_a", 32'(sel_a), 32'h2);
      step();
      stall = 0; idle_fwd();

      // x0 is never forwarded
      id_instr(1, 1, 0, 1, 0, 11, 32'h108);
      step();
      stall = 1; id_valid = 0;
      mem_wren = 1; mem_rd = 0; mem_data = 32'hFFFF_0000;
      sample();
      chk("x0_op_b", op_b, 32'h0);
      chk("x0_sel_b", 32'(sel_b), 32'h0);
      step();
      stall = 0; idle_fwd();

      // Load-use: lw x7 followed by a consumer of x7 on rs2
      id_instr(1, 1, 1, 2, 2, 7, 32'h10C);
      step();
      id_instr(1, 1, 0, 1, 7, 12, 32'h110);
      id_use_rs1 = 0;
      sample();
      chk("lu_flag", 32'(load_use), 32'h1);
      step();
      chk("lu_bubble", 32'(ex_valid), 32'h0);
      wb_wren = 1; wb_rd = 7; wb_data = 32'h5A5A_5A5A;
      step();
      idle_fwd();
      sample();
      chk("lu_consumer_valid", 32'(ex_valid), 32'h1);
      chk("lu_consumer_op_b", op_b, 32'h5A5A_5A5A);

      // Flush wins over stall, then a held stall
      flush = 1; stall = 1;
      step();
      chk("flush_stall_valid", 32'(ex_valid), 32'h0);
      flush = 0; stall = 0;
      id_instr(1, 1, 0, 8, 9, 13, 32'h200);
      step();
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         id_instr(1, 0, 1, 5'(k), 5'(k + 4), 5'(k + 1), 32'h300 + 32'(k));
         step();
         chk("stall_pc", ex_pc, 32'h200);
      end
      stall = 0;

      // Asynchronous reset between edges with a valid slot
      id_instr(1, 1, 0, 4, 5, 14, 32'h400);
      step();
      rst_n = 0;
      #1;
      chk("async_rst_valid", 32'(ex_valid), 32'h0);
      chk("async_rst_pc", ex_pc, 32'h0);
      slot = '0;
      sample();
      step();
      @(negedge clk);
      rst_n = 1;
      id_instr(1, 1, 0, 6, 7, 15, 32'h500);
      step();
      chk("post_rst_pc", ex_pc, 32'h500);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 99) < 15);
         flush = ($urandom_range(0, 99) < 8);
         id_instr($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 9) < 3,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom);
         id_use_rs1 = $urandom_range(0, 1);
         id_use_rs2 = $urandom_range(0, 1);
         id_imm = $urandom;
         wb_wren = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
         mem_wren = $urandom_range(0, 1); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
         if ($urandom_range(0, 3) == 0) sample();
         step();
      end

      #2;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/idex_operand_stage.md
IDEX_OPERAND_STAGE -- requirements
Module: idex_operand_stage

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath width.
REQ-002 The block SHALL have port i_clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port i_stall, input, 1, global pipeline hold.
REQ-005 The block SHALL have port i_flush, input, 1, kill the ID/EX slot (branch/JALR mispredict).
REQ-006 The block SHALL have ports i_id_valid, i_id_rd_wren, i_id_is_load, i_id_use_rs1 and i_id_use_rs2, each input, 1, ID-stage instruction qualifiers.
REQ-007 The block SHALL have ports i_id_rs1_addr, i_id_rs2_addr and i_id_rd_addr, each input, 5, ID-stage register indices.
REQ-008 The block SHALL have ports i_id_pc and i_id_imm, each input, XLEN, ID-stage PC and decoded immediate.
REQ-009 The block SHALL have ports i_rs1_data and i_rs2_data, each input, XLEN, register-file read data (x0 already reads 0).
REQ-010 The block SHALL have ports i_wb_wren (1), i_wb_rd_addr (5) and i_wb_rd_data (XLEN), each input, WB write port, identical to the register-file write inputs.
REQ-011 The block SHALL have ports i_mem_wren (1), i_mem_rd_addr (5) and i_mem_alu_data (XLEN), each input, EX/MEM destination and ALU result.
REQ-012 The block SHALL have ports o_ex_valid, o_ex_rd_wren and o_ex_is_load, each output, 1, registered EX-slot qualifiers.
REQ-013 The block SHALL have ports o_ex_rs1_addr, o_ex_rs2_addr and o_ex_rd_addr, each output, 5, registered indices.
REQ-014 The block SHALL have ports o_ex_pc and o_ex_imm, each output, XLEN, registered PC and immediate.
REQ-015 The block SHALL have ports o_ex_op_a and o_ex_op_b, each output, XLEN, forwarded EX operands (combinational).
REQ-016 The block SHALL have ports o_fwd_sel_a and o_fwd_sel_b, each output, 2, forwarding source: 00 ID/EX register, 01 MEM, 10 WB.
REQ-017 The block SHALL have port o_load_use, output, 1, combinational load-use stall request to IF/ID.

Function
REQ-018 At capture, the rs1 operand SHALL be i_wb_rd_data when i_wb_wren=1, i_wb_rd_addr!=0 and i_wb_rd_addr==i_id_rs1_addr, and i_rs1_data otherwise; rs2 SHALL be captured likewise.
REQ-019 Register update priority SHALL be: reset > i_flush > i_stall > load-use bubble > normal capture.
REQ-020 On i_flush, next-cycle o_ex_valid, o_ex_rd_wren and o_ex_is_load SHALL be 0; other fields are don't-care; i_flush overrides i_stall.
REQ-021 On i_stall without i_flush, every ID/EX register SHALL hold its value.
REQ-022 o_load_use SHALL be i_id_valid & o_ex_valid & o_ex_is_load & (o_ex_rd_addr!=0) & ((i_id_use_rs1 & rs1 match) | (i_id_use_rs2 & rs2 match)).
REQ-023 When o_load_use=1, with no i_stall and no i_flush, the next cycle SHALL hold a bubble (valid, rd_wren and is_load all 0); the ID instruction is re-presented by the upstream stages.
REQ-024 Normal capture SHALL load all ID fields with one-cycle latency; rd_wren and is_load are gated by i_id_valid.
REQ-025 o_ex_op_a SHALL select MEM when i_mem_wren=1, i_mem_rd_addr!=0 and i_mem_rd_addr==o_ex_rs1_addr; otherwise WB under the same rule; otherwise the captured rs1.
REQ-026 MEM SHALL have priority over WB; index 0 SHALL never be forwarded; o_ex_op_b SHALL follow the same rules on rs2.
REQ-027 o_fwd_sel_a and o_fwd_sel_b SHALL encode the source actually selected, and SHALL be 00 when o_ex_valid=0.

Reset
REQ-028 While i_rst_n=0, every ID/EX register SHALL be 0 asynchronously, giving o_ex_valid=0, o_ex_pc=0, o_ex_op_a=0 (no forwarding match) and o_load_use=0.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight slot; the first capture SHALL occur on the first rising edge after deassertion.

Verification
REQ-030 WB bypass: i_wb_wren=1, wb_rd=5, wb_data=0xDEADBEEF, id_rs1=5, i_rs1_data=0x11 -> next cycle o_ex_op_a=0xDEADBEEF, sel_a=00.
REQ-031 Double hazard: EX rs1=3, MEM rd=3 alu=0xA, WB rd=3 data=0xB -> o_ex_op_a=0xA, sel_a=01; with MEM wren=0 -> 0xB, sel_a=10.
REQ-032 x0: MEM rd=0 wren=1, EX rs2=0 -> o_ex_op_b=captured 0, sel_b=00.
REQ-033 Load-use: EX lw rd=7, ID rs2=7, use_rs2=1 -> o_load_use=1, next o_ex_valid=0; then the load reaches WB and the consumer captures via WB bypass.
REQ-034 Flush with stall: i_flush=1 and i_stall=1 together -> next o_ex_valid=0; stall alone for 3 cycles -> all outputs constant.
REQ-035 Async reset: drop i_rst_n between edges with the slot valid -> o_ex_valid=0 immediately, without waiting for a clock edge.
